// File: rtl/decoder_pkg.sv
// Shared types for the line decoder family: scan FSM states and mode encodings.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decode, shared by the direct and scan paths.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [2**SEL_W-1:0] y
);

  always_comb begin
    y      = '0;
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot line decoder with direct-select mode and an autonomous dwell-timed scan.
// Handshake: start is a single-cycle request honoured only in IDLE with en=1, mode=1; done pulses once per completed one-shot scan.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 start,
  input  logic                 cont,
  output logic [2**SEL_W-1:0]  y,
  output logic [SEL_W-1:0]     idx,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_W = 2**SEL_W;
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

  state_e           state, state_n;
  logic [DW_W-1:0]  cnt, cnt_n;
  logic [SEL_W-1:0] idx_n;
  logic             cont_q, cont_n;
  logic             done_n;
  logic             y_on;
  logic [OUT_W-1:0] dec_y;

  // The decoder always sees the next index, so y and idx can never disagree.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel (idx_n),
    .y   (dec_y)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    cont_n  = cont_q;
    done_n  = 1'b0;
    y_on    = 1'b0;
    case (state)
      IDLE: begin
        if (en && mode == MODE_DIRECT) begin
          idx_n = sel;
          y_on  = 1'b1;
        end else if (en && mode == MODE_SCAN && start) begin
          state_n = SCAN;
          idx_n   = '0;
          cnt_n   = '0;
          cont_n  = cont;
          y_on    = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DW_LAST) begin
          cnt_n = '0;
          if (idx != LAST_IDX) begin
            idx_n = idx + SEL_W'(1);
            y_on  = 1'b1;
          end else if (cont_q) begin
            idx_n = '0;
            y_on  = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt + DW_W'(1);
          y_on  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      y      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cont_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      y      <= y_on ? dec_y : '0;
      busy   <= (state_n == SCAN);
      done   <= done_n;
      cont_q <= cont_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboarded bench for decoder_scan: main instance (SEL_W=3, DWELL=4) and a DWELL=1, SEL_W=1 corner instance.
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;

  logic       m_en, m_mode, m_start, m_cont;
  logic [2:0] m_sel;
  logic [7:0] m_y;
  logic [2:0] m_idx;
  logic       m_busy, m_done;

  logic       c_en, c_mode, c_start, c_cont;
  logic [0:0] c_sel;
  logic [1:0] c_y;
  logic [0:0] c_idx;
  logic       c_busy, c_done;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {busy, done, idx, y} after each clock edge.
  logic [12:0] exp_q[$];
  logic [4:0]  c_exp_q[$];
  logic [2:0]  last_idx;

  decoder_scan #(.SEL_W(3), .DWELL(4)) u_main (
    .clk(clk), .rst_n(rst_n), .en(m_en), .mode(m_mode), .sel(m_sel),
    .start(m_start), .cont(m_cont), .y(m_y), .idx(m_idx), .busy(m_busy), .done(m_done)
  );

  decoder_scan #(.SEL_W(1), .DWELL(1)) u_corner (
    .clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .sel(c_sel),
    .start(c_start), .cont(c_cont), .y(c_y), .idx(c_idx), .busy(c_busy), .done(c_done)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_m(input logic b, input logic d, input logic [2:0] i, input logic [7:0] yy);
    exp_q.push_back({b, d, i, yy});
    last_idx = i;
  endtask

  // Advance one clock, then pop and compare the scoreboard entries.
  task automatic tick();
    logic [12:0] e;
    logic [4:0]  ce;
    @(posedge clk);
    #1;
    check("sb_level", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("m_y",    m_y,    e[7:0]);
      check("m_idx",  m_idx,  e[10:8]);
      check("m_done", m_done, e[11]);
      check("m_busy", m_busy, e[12]);
    end
    if (c_exp_q.size() != 0) begin
      ce = c_exp_q.pop_front();
      check("c_y",    c_y,    ce[1:0]);
      check("c_idx",  c_idx,  ce[2]);
      check("c_done", c_done, ce[3]);
      check("c_busy", c_busy, ce[4]);
    end
    check("m_onehot", $onehot0(m_y), 1);
    check("c_onehot", $onehot0(c_y), 1);
  endtask

  // Scan of n active cycles; disturb toggles inputs that must be ignored while busy.
  task automatic run_scan(input logic c, input logic disturb, input int n);
    int kk;
    m_en = 1'b1; m_mode = 1'b1; m_cont = c; m_start = 1'b1;
    expect_m(1'b1, 1'b0, 3'd0, 8'h01);
    tick();
    m_start = 1'b0;
    for (int k = 1; k < n; k++) begin
      if (disturb) begin
        m_sel   = 3'($urandom_range(0, 7));
        m_mode  = 1'($urandom_range(0, 1));
        m_cont  = 1'($urandom_range(0, 1));
        m_start = 1'($urandom_range(0, 1));
      end
      kk = k % 32;
      expect_m(1'b1, 1'b0, 3'(kk / 4), 8'(1 << (kk / 4)));
      tick();
    end
    m_mode = 1'b1; m_start = 1'b0; m_cont = 1'b0; m_sel = 3'd0;
  endtask

  task automatic oneshot_tail();
    expect_m(1'b0, 1'b0, 3'd7, 8'h00);
    tick();
    expect_m(1'b0, 1'b1, 3'd7, 8'h00);
    tick();
    expect_m(1'b0, 1'b0, 3'd7, 8'h00);
    tick();
  endtask

  initial begin
    logic [2:0] s;
    rst_n = 1'b0;
    m_en = 1'b0; m_mode = 1'b0; m_start = 1'b0; m_cont = 1'b0; m_sel = 3'd0;
    c_en = 1'b0; c_mode = 1'b0; c_start = 1'b0; c_cont = 1'b0; c_sel = 1'b0;
    last_idx = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y",    m_y,    0);
    check("rst_idx",  m_idx,  0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_c_y",  c_y,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct decode
    m_en = 1'b1; m_mode = 1'b0; m_sel = 3'd5;
    expect_m(1'b0, 1'b0, 3'd5, 8'b0010_0000);
    tick();
    for (int i = 0; i < 6; i++) begin
      s = 3'($urandom_range(0, 7));
      m_sel = s;
      expect_m(1'b0, 1'b0, s, 8'(1 << s));
      tick();
    end
    m_en = 1'b0;
    expect_m(1'b0, 1'b0, last_idx, 8'h00);
    tick();

    // Clean one-shot scan
    run_scan(1'b0, 1'b0, 32);
    oneshot_tail();

    // Continuous scan wraps, then en=0 aborts without done
    run_scan(1'b1, 1'b0, 40);
    m_en = 1'b0;
    expect_m(1'b0, 1'b0, last_idx, 8'h00);
    tick();
    expect_m(1'b0, 1'b0, last_idx, 8'h00);
    tick();

    // start ignored with en=0, and with mode=0 (direct decode instead)
    m_en = 1'b0; m_mode = 1'b1; m_start = 1'b1;
    expect_m(1'b0, 1'b0, last_idx, 8'h00);
    tick();
    m_en = 1'b1; m_mode = 1'b0; m_sel = 3'd2;
    expect_m(1'b0, 1'b0, 3'd2, 8'h04);
    tick();
    m_start = 1'b0;

    // One-shot with disturbing inputs matches the clean sequence
    run_scan(1'b0, 1'b1, 32);
    oneshot_tail();

    // Asynchronous reset mid-scan at idx=3
    run_scan(1'b1, 1'b0, 14);
    check("pre_rst_idx", m_idx, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y",    m_y,    0);
    check("arst_idx",  m_idx,  0);
    check("arst_busy", m_busy, 0);
    check("arst_done", m_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_en = 1'b1; m_mode = 1'b1; m_start = 1'b0;
    expect_m(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    expect_m(1'b0, 1'b0, 3'd0, 8'h00);
    tick();

    // Corner instance: DWELL=1, SEL_W=1 one-shot
    c_en = 1'b1; c_mode = 1'b1; c_cont = 1'b0; c_start = 1'b1;
    c_exp_q.push_back({1'b1, 1'b0, 1'b0, 2'b01});
    c_exp_q.push_back({1'b1, 1'b0, 1'b1, 2'b10});
    c_exp_q.push_back({1'b0, 1'b0, 1'b1, 2'b00});
    c_exp_q.push_back({1'b0, 1'b1, 1'b1, 2'b00});
    c_exp_q.push_back({1'b0, 1'b0, 1'b1, 2'b00});
    expect_m(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_m(1'b0, 1'b0, 3'd0, 8'h00);
      tick();
    end
    check("c_sb_drained", c_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
